mux_8_1_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single 4-bit, 8-input multiplexer path among eight requesters. It grants one requester at a time, drives the 3-bit select and one-hot grant, and routes the granted requester's nibble to the shared output. A hold limit bounds how long one requester keeps the path while others wait.

---
 rtl/mux_8_1_rr_arbiter_pkg.sv | 16 +
 rtl/mux_8_1_rr_arbiter_if.sv | 23 ++
 rtl/mux_8_1_rr_arbiter_rr_pick8.sv | 31 +++
 rtl/mux_8_1_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux_8_1_rr_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_8_1_rr_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the 8-way round-robin nibble arbiter.
package mux_8_1_rr_arbiter_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_8_1_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters and the arbiter.
interface mux_8_1_rr_arbiter_if;
  import mux_8_1_rr_arbiter_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [DATA_W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [N_REQ-1:0]  gnt;
  logic [SEL_W-1:0]  sel;
  logic              valid;
  logic [DATA_W-1:0] y;
  logic [CNT_W-1:0]  hold_cnt;

  modport master (
    output req, d0, d1, d2, d3, d4, d5, d6, d7,
    input  gnt, sel, valid, y, hold_cnt
  );

  modport slave (
    input  req, d0, d1, d2, d3, d4, d5, d6, d7,
    output gnt, sel, valid, y, hold_cnt
  );

endinterface

// File: rtl/mux_8_1_rr_arbiter_rr_pick8.sv
// Rotating priority encoder: first set, non-excluded request at or after start_i, wrapping 7->0.
module rr_pick8
  import mux_8_1_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] start_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [N_REQ-1:0] masked;
  logic [SEL_W-1:0] k;

  assign masked = req_i & ~excl_i;

  // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    k       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = start_i + SEL_W'(i);
      if (masked[k]) begin
        found_o = 1'b1;
        idx_o   = k;
      end
    end
  end

endmodule

// File: rtl/mux_8_1_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 nibble mux among eight requesters, with a bounded hold time.
module mux_8_1_rr_arbiter
  import mux_8_1_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic                   clk,
  input logic                   rst,
  mux_8_1_rr_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = '1;

  logic [0:0]        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [CNT_W-1:0]  hold_q, hold_d;

  logic              cur_req;
  logic              others;
  logic              keep;
  logic [N_REQ-1:0]  excl;
  logic              found;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] d_arr [N_REQ];

  assign cur_req = |(bus.req & gnt_q);
  assign others  = |(bus.req & ~gnt_q);
  assign keep    = cur_req && ((hold_q < HOLD_LIM) || !others);
  // A still-requesting owner is skipped only when someone else is waiting.
  assign excl    = (state_q == GRANT && cur_req && others) ? gnt_q : '0;

  rr_pick8 u_pick (
    .req_i   (bus.req),
    .start_i (ptr_q + SEL_W'(1)),
    .excl_i  (excl),
    .found_o (found),
    .idx_o   (idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = idx;
          gnt_d   = onehot(idx);
          ptr_d   = idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (keep) begin
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + CNT_W'(1);
        end else if (found) begin
          sel_d  = idx;
          gnt_d  = onehot(idx);
          ptr_d  = idx;
          hold_d = '0;
        end else begin
          state_d = IDLE;
          sel_d   = '0;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(N_REQ - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  assign d_arr[0] = bus.d0;
  assign d_arr[1] = bus.d1;
  assign d_arr[2] = bus.d2;
  assign d_arr[3] = bus.d3;
  assign d_arr[4] = bus.d4;
  assign d_arr[5] = bus.d5;
  assign d_arr[6] = bus.d6;
  assign d_arr[7] = bus.d7;

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.valid    = (state_q == GRANT);
  assign bus.hold_cnt = hold_q;
  assign bus.y        = (state_q == GRANT) ? d_arr[sel_q] : '0;

endmodule

// File: tb/tb_mux_8_1_rr_arbiter.sv
// Bench for mux_8_1_rr_arbiter: two instances (MAX_HOLD=4 and 1) against a queue-free behavioural model.
module tb_mux_8_1_rr_arbiter;
  import mux_8_1_rr_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [3:0] d [8];

  int n_chk  = 0;
  int n_pass = 0;

  int m_own  [2];
  int m_ptr  [2];
  int m_hold [2];
  int lim    [2];

  always #5 clk = ~clk;

  mux_8_1_rr_arbiter_if ifa ();
  mux_8_1_rr_arbiter_if ifb ();

  assign ifa.req = req;
  assign ifb.req = req;
  assign ifa.d0 = d[0]; assign ifa.d1 = d[1]; assign ifa.d2 = d[2]; assign ifa.d3 = d[3];
  assign ifa.d4 = d[4]; assign ifa.d5 = d[5]; assign ifa.d6 = d[6]; assign ifa.d7 = d[7];
  assign ifb.d0 = d[0]; assign ifb.d1 = d[1]; assign ifb.d2 = d[2]; assign ifb.d3 = d[3];
  assign ifb.d4 = d[4]; assign ifb.d5 = d[5]; assign ifb.d6 = d[6]; assign ifb.d7 = d[7];

  mux_8_1_rr_arbiter #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux_8_1_rr_arbiter #(.MAX_HOLD(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference behaviour: owner index (-1 when idle), last winner, cycles held.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_own[i] = -1; m_ptr[i] = 7; m_hold[i] = 0;
      end else if (m_own[i] < 0) begin
        for (int o = 1; o <= 8; o++) begin
          int k;
          k = (m_ptr[i] + o) % 8;
          if (req[k] && m_own[i] < 0) begin
            m_own[i] = k; m_ptr[i] = k; m_hold[i] = 0;
          end
        end
      end else begin
        int  g;
        int  w;
        bit  oth;
        g   = m_own[i];
        oth = 1'b0;
        for (int k = 0; k < 8; k++) if (k != g && req[k]) oth = 1'b1;
        if (req[g] && (m_hold[i] < lim[i] - 1 || !oth)) begin
          m_hold[i] = (m_hold[i] < 15) ? m_hold[i] + 1 : 15;
        end else begin
          w = -1;
          for (int o = 1; o < 8; o++) if (w < 0 && req[(g + o) % 8]) w = (g + o) % 8;
          if (w >= 0) begin
            m_own[i] = w; m_ptr[i] = w; m_hold[i] = 0;
          end else begin
            m_own[i] = -1; m_hold[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] g;
      logic [2:0] s;
      logic       v;
      logic [3:0] yy;
      logic [3:0] h;
      if (i == 0) begin
        g = ifa.gnt; s = ifa.sel; v = ifa.valid; yy = ifa.y; h = ifa.hold_cnt;
      end else begin
        g = ifb.gnt; s = ifb.sel; v = ifb.valid; yy = ifb.y; h = ifb.hold_cnt;
      end
      chk($sformatf("m%0d_valid", i), 32'(v), 32'(m_own[i] >= 0));
      chk($sformatf("m%0d_gnt", i), 32'(g), (m_own[i] >= 0) ? (32'd1 << m_own[i]) : 32'd0);
      chk($sformatf("m%0d_y", i), 32'(yy), (m_own[i] >= 0) ? 32'(d[m_own[i]]) : 32'd0);
      if (m_own[i] >= 0) begin
        chk($sformatf("m%0d_sel", i), 32'(s), 32'(m_own[i]));
        chk($sformatf("m%0d_hold", i), 32'(h), 32'(m_hold[i]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] rot_a [4];
  logic [7:0] rot_b [3];

  initial begin
    lim[0] = 4; lim[1] = 1;
    for (int i = 0; i < 2; i++) begin m_own[i] = -1; m_ptr[i] = 7; m_hold[i] = 0; end
    for (int i = 0; i < 8; i++) d[i] = 4'(i + 1);
    rot_a[0] = 8'h01; rot_a[1] = 8'h10; rot_a[2] = 8'h80; rot_a[3] = 8'h01;
    rot_b[0] = 8'h01; rot_b[1] = 8'h10; rot_b[2] = 8'h80;

    // Reset with everyone requesting, then first grant goes to 0.
    rst = 1'b1; req = 8'hFF;
    tick();
    tick();
    chk("rst_gnt", 32'(ifa.gnt), 32'h00);
    chk("rst_valid", 32'(ifa.valid), 32'd0);
    chk("rst_y", 32'(ifa.y), 32'h0);
    rst = 1'b0;
    tick();
    chk("first_gnt", 32'(ifa.gnt), 32'h01);
    chk("first_sel", 32'(ifa.sel), 32'd0);

    // Single requester holds past MAX_HOLD and saturates its counter.
    do_reset();
    req = 8'h20; d[5] = 4'hA;
    tick();
    chk("single_gnt", 32'(ifa.gnt), 32'h20);
    chk("single_sel", 32'(ifa.sel), 32'd5);
    chk("single_y", 32'(ifa.y), 32'hA);
    repeat (20) tick();
    chk("single_sat", 32'(ifa.hold_cnt), 32'hF);
    chk("single_b_gnt", 32'(ifb.gnt), 32'h20);
    req = 8'h00;
    tick();
    chk("single_drop", 32'(ifa.valid), 32'd0);

    // Fair rotation 0,4,7 with back-to-back hand-offs.
    do_reset();
    req = 8'h91;
    for (int c = 0; c < 13; c++) begin
      tick();
      chk($sformatf("rot_a_%0d", c), 32'(ifa.gnt), 32'(rot_a[c / 4]));
      chk($sformatf("rot_b_%0d", c), 32'(ifb.gnt), 32'(rot_b[c % 3]));
      chk($sformatf("rot_v_%0d", c), 32'(ifa.valid), 32'd1);
    end

    // Early release hands over immediately.
    do_reset();
    req = 8'h44;
    tick();
    chk("early_first", 32'(ifa.gnt), 32'h04);
    req = 8'h40;
    tick();
    chk("early_gnt", 32'(ifa.gnt), 32'h40);
    chk("early_hold", 32'(ifa.hold_cnt), 32'd0);

    // Wrap-around from ptr=7 and from ptr=6.
    do_reset();
    req = 8'h81;
    tick();
    chk("wrap7", 32'(ifa.gnt), 32'h01);
    do_reset();
    req = 8'h40;
    tick();
    req = 8'h81;
    tick();
    chk("wrap6", 32'(ifa.gnt), 32'h80);
    chk("wrap6_sel", 32'(ifa.sel), 32'd7);

    // Reset in the middle of a grant.
    do_reset();
    req = 8'h08;
    repeat (3) tick();
    chk("mid_hold", 32'(ifa.hold_cnt), 32'd2);
    rst = 1'b1;
    tick();
    chk("mid_gnt", 32'(ifa.gnt), 32'h00);
    chk("mid_sel", 32'(ifa.sel), 32'd0);
    chk("mid_hold0", 32'(ifa.hold_cnt), 32'd0);
    chk("mid_y", 32'(ifa.y), 32'h0);
    rst = 1'b0; req = 8'h0A;
    tick();
    chk("mid_regrant", 32'(ifa.gnt), 32'h02);

    // Random traffic, data churn within the cycle, occasional reset.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) req[$urandom_range(0, 7)] ^= 1'b1;
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < 8; i++) d[i] = 4'($urandom);
      tick();
      for (int i = 0; i < 8; i++) d[i] = 4'($urandom);
      #1;
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
